mem_data_arb: RTL and testbench
===============================

// Module: mem_data_arb
// PURPOSE
//  Two-requester arbiter sequencing one mem_data instance (1 write port, 1 registered read port, 1-cycle read).
//  Requester 0 = processor core load/store unit, requester 1 = external/DMA port. One memory op granted per cycle;
//  read data returned one cycle after grant with a per-requester valid strobe. Optional lock keeps ownership for bursts.
// PARAMETERS
//  NADDRE   8    memory depth in words; address width AW = $clog2(NADDRE)
//  NBDATA   32   data word width (signed, passed through unchanged)
// PORTS
//  clk          in   1       rising-edge clock, single clock domain
//  rst          in   1       synchronous, active-high reset
//  rN_req       in   1       (N=0,1) request valid; hold with rN_wr/addr/wdata stable until rN_gnt
//  rN_wr        in   1       1 = write, 0 = read
//  rN_addr      in   AW      word address
//  rN_wdata     in   NBDATA  write data (signed)
//  rN_lock      in   1       keep ownership after this grant (burst)
//  rN_gnt       out  1       request accepted this cycle (combinational from req/state)
//  rN_rvalid    out  1       registered; rN_rdata valid this cycle
//  rN_rdata     out  NBDATA  = mem_data_out (shared by both requesters, qualify with rN_rvalid)
//  mem_wr       out  1       to mem_data.wr
//  mem_addr_w   out  AW      to mem_data.addr_w
//  mem_addr_r   out  AW      to mem_data.addr_r
//  mem_data_in  out  NBDATA  to mem_data.data_in
//  mem_data_out in   NBDATA  from mem_data.data_out
// BEHAVIOUR
//  - Reset: state=ARB, last_winner=1 (so r0 wins first tie), rN_rvalid=0; rN_gnt=0 unless rN_req (comb).
//  - At most one rN_gnt per cycle. Winner drives mem port: write -> mem_wr=1, mem_addr_w=addr,
//    mem_data_in=wdata; read -> mem_wr=0, mem_addr_r=addr. No grant -> mem_wr=0, addresses/data hold last value.
//  - Read latency: grant at edge N -> mem_data_out valid after edge N+1; rN_rvalid asserted for exactly that
//    cycle (register of gnt&~wr). Back-to-back reads sustain 1 word/cycle.
//  - Write at cycle N, read same address at N+1 returns the new data (no hazard; one op/cycle).
//  - FSM: ARB -> OWN0 when r0 granted with r0_lock=1; ARB -> OWN1 likewise for r1.
//    OWNn: only rn may be granted; other requester stalls. OWNn -> ARB on a grant with rn_lock=0,
//    or when rn_req=0 (owner dropped request: release, no grant that cycle from OWNn; arbitrate next cycle).
//  - Tie in ARB (both req): see CONFIGURATION. Single req in ARB: always granted same cycle.
//  - last_winner updates on every grant.
//  - Reset mid-operation: pending rvalid dropped (rvalid=0 next cycle), lock released, any in-flight write
//    granted in the reset cycle is NOT issued (mem_wr forced 0 while rst=1).
//  - Widths: no arithmetic; addresses/data passed bit-exact, no sign/zero extension.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: ties in ARB go round-robin (requester != last_winner).
//  MEM_ARB_RR_EN undefined: fixed priority, r0 always wins ties; last_winner kept but unused (r1 may starve).
// STRUCTURE
//  Package mem_arb_pkg: state enum {ARB, OWN0, OWN1}, requester IDs REQ_CORE=0, REQ_EXT=1, op codes OP_RD/OP_WR.
//  Sub-module mem_arb_pick: 2-way combinational grant picker (req[1:0], last_winner, mode) -> onehot gnt.
//  Top holds FSM, last_winner, rvalid pipeline and mem port muxing; mem_data instantiated by the parent.
// TESTING
//  1. Reset then r0 write addr 3 = 0x0000_00A5, then r0 read addr 3 -> r0_gnt each cycle, r0_rvalid 1 cycle later, rdata 0xA5.
//  2. r0,r1 both read every cycle (addr 1 / 2), RR on -> grants alternate r0,r1,r0...; rvalid follows owning req by 1 cycle.
//  3. Same as 2 with MEM_ARB_RR_EN off -> r0 granted every cycle, r1_gnt never 1.
//  4. r1 lock=1 for 4 writes addr 4..7 while r0 requests -> r0 stalled 4 cycles, granted cycle after r1 lock=0 write.
//  5. r0 write addr 0 = -1 and r1 read addr 0 next cycle -> r1_rdata = 0xFFFF_FFFF (signed -1).
//  6. rst asserted the cycle after a r1 read grant -> r1_rvalid=0, state=ARB, mem_wr=0 during reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_data two-requester arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_EXT  = 1'b1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way combinational grant picker; mode=1 selects round-robin ties, mode=0 fixed r0 priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  input  logic       mode,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      // On a tie, round-robin hands the slot to whoever did not win last.
      if (mode && (last_winner == REQ_CORE)) gnt = 2'b10;
      else                                   gnt = 2'b01;
    end
  end

endmodule

// File: rtl/mem_data_arb.sv
// Arbiter sequencing one mem_data instance between the core LSU (r0) and an external/DMA port (r1).
// Build option: define MEM_ARB_RR_EN for round-robin ties; otherwise r0 always wins ties.
module mem_data_arb
  import mem_arb_pkg::*;
#(
  parameter  int NADDRE = 8,
  parameter  int NBDATA = 32,
  localparam int AW     = $clog2(NADDRE)
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: rN_req is a valid that holds wr/addr/wdata/lock stable until rN_gnt;
  // rN_gnt is the combinational ready, and the op transfers in the cycle where both are high.
  input  logic              r0_req,
  input  logic              r0_wr,
  input  logic [AW-1:0]     r0_addr,
  input  logic [NBDATA-1:0] r0_wdata,
  input  logic              r0_lock,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [NBDATA-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_wr,
  input  logic [AW-1:0]     r1_addr,
  input  logic [NBDATA-1:0] r1_wdata,
  input  logic              r1_lock,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [NBDATA-1:0] r1_rdata,
  output logic              mem_wr,
  output logic [AW-1:0]     mem_addr_w,
  output logic [AW-1:0]     mem_addr_r,
  output logic [NBDATA-1:0] mem_data_in,
  input  logic [NBDATA-1:0] mem_data_out,
  output logic [1:0]        dbg_state
);

  arb_state_t        state, state_nx;
  logic              last_winner;
  logic              rr_mode;
  logic [1:0]        pick_gnt;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel_wr;
  logic [AW-1:0]     sel_addr;
  logic [NBDATA-1:0] sel_wdata;
  logic [AW-1:0]     addr_w_q;
  logic [AW-1:0]     addr_r_q;
  logic [NBDATA-1:0] data_in_q;

`ifdef MEM_ARB_RR_EN
  assign rr_mode = 1'b1;
`else
  assign rr_mode = 1'b0;
`endif

  mem_arb_pick u_pick (
    .req         ({r1_req, r0_req}),
    .last_winner (last_winner),
    .mode        (rr_mode),
    .gnt         (pick_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nx;
  end

  // An owner that drops its request releases the lock without taking the slot.
  always_comb begin
    state_nx = state;
    case (state)
      ARB: begin
        if (gnt[0] && r0_lock)      state_nx = OWN0;
        else if (gnt[1] && r1_lock) state_nx = OWN1;
      end
      OWN0:    if (!r0_req || !r0_lock) state_nx = ARB;
      OWN1:    if (!r1_req || !r1_lock) state_nx = ARB;
      default: state_nx = ARB;
    endcase
  end

  always_comb begin
    gnt = 2'b00;
    case (state)
      ARB:     gnt = pick_gnt;
      OWN0:    gnt = {1'b0, r0_req};
      OWN1:    gnt = {r1_req, 1'b0};
      default: gnt = 2'b00;
    endcase
  end

  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign dbg_state = state;

  assign any_gnt   = |gnt;
  assign sel_wr    = gnt[1] ? r1_wr    : r0_wr;
  assign sel_addr  = gnt[1] ? r1_addr  : r0_addr;
  assign sel_wdata = gnt[1] ? r1_wdata : r0_wdata;

  // Idle cycles present the last address/data so the memory pins stay quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_w_q  <= '0;
      addr_r_q  <= '0;
      data_in_q <= '0;
    end else if (any_gnt && sel_wr) begin
      addr_w_q  <= sel_addr;
      data_in_q <= sel_wdata;
    end else if (any_gnt) begin
      addr_r_q  <= sel_addr;
    end
  end

  assign mem_wr      = any_gnt && sel_wr && !rst;
  assign mem_addr_w  = (any_gnt &&  sel_wr) ? sel_addr  : addr_w_q;
  assign mem_data_in = (any_gnt &&  sel_wr) ? sel_wdata : data_in_q;
  assign mem_addr_r  = (any_gnt && !sel_wr) ? sel_addr  : addr_r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= REQ_EXT;
      r0_rvalid   <= 1'b0;
      r1_rvalid   <= 1'b0;
    end else begin
      if (gnt[1])      last_winner <= REQ_EXT;
      else if (gnt[0]) last_winner <= REQ_CORE;
      r0_rvalid <= gnt[0] && (r0_wr == OP_RD);
      r1_rvalid <= gnt[1] && (r1_wr == OP_RD);
    end
  end

  assign r0_rdata = mem_data_out;
  assign r1_rdata = mem_data_out;

endmodule

// File: tb/tb_mem_data_arb.sv
// Self-checking bench for mem_data_arb with a behavioural mem_data model attached.
module tb_mem_data_arb;
  import mem_arb_pkg::*;

  localparam int NADDRE = 8;
  localparam int NBDATA = 32;
  localparam int AW     = $clog2(NADDRE);
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_req, r0_wr, r0_lock, r0_gnt, r0_rvalid;
  logic [AW-1:0]     r0_addr;
  logic [NBDATA-1:0] r0_wdata, r0_rdata;
  logic              r1_req, r1_wr, r1_lock, r1_gnt, r1_rvalid;
  logic [AW-1:0]     r1_addr;
  logic [NBDATA-1:0] r1_wdata, r1_rdata;
  logic              mem_wr;
  logic [AW-1:0]     mem_addr_w, mem_addr_r;
  logic [NBDATA-1:0] mem_data_in, mem_data_out;
  logic [1:0]        dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  mem_data_arb #(.NADDRE(NADDRE), .NBDATA(NBDATA)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_wr(mem_wr), .mem_addr_w(mem_addr_w), .mem_addr_r(mem_addr_r),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .dbg_state(dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  logic [NBDATA-1:0] ram [NADDRE];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr_w] <= mem_data_in;
    mem_data_out <= ram[mem_addr_r];
  end

  // driver tasks
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive0(input logic req, input logic wr, input logic lock,
                        input logic [AW-1:0] a, input logic [NBDATA-1:0] d);
    r0_req = req; r0_wr = wr; r0_lock = lock; r0_addr = a; r0_wdata = d;
  endtask

  task automatic drive1(input logic req, input logic wr, input logic lock,
                        input logic [AW-1:0] a, input logic [NBDATA-1:0] d);
    r1_req = req; r1_wr = wr; r1_lock = lock; r1_addr = a; r1_wdata = d;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_r0_rvalid", r0_rvalid, 0);
    check("rst_r1_rvalid", r1_rvalid, 0);
    check("rst_state", dbg_state, ARB);
    check("rst_gnt", {r1_gnt, r0_gnt}, 0);
    check("rst_mem_wr", mem_wr, 0);
  endtask

  // table vectors
  typedef struct packed {
    logic q0, w0, l0, q1, w1, l1, e0, e1;
  } vec_t;
  vec_t vecs [14];

  // scoreboard / reference model
  logic [NBDATA-1:0] exp_q [$];
  logic [NBDATA-1:0] mmem [NADDRE];

  initial begin
    logic [NBDATA-1:0] exp_d;
    logic p0, p1, w0, w1, l0, l1, g0, g1, erv0, erv1, lw;
    logic [AW-1:0] a0, a1;
    logic [NBDATA-1:0] d0, d1;
    int owner;

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    do_reset();

    // write then read back (0xA5 at addr 3)
    @(negedge clk); drive0(1, OP_WR, 0, 3'd3, 32'h0000_00A5); #1;
    check("t1_wr_gnt", r0_gnt, 1);
    check("t1_mem_wr", mem_wr, 1);
    check("t1_addr_w", mem_addr_w, 3);
    check("t1_data_in", mem_data_in, 32'hA5);
    @(negedge clk); drive0(1, OP_RD, 0, 3'd3, '0); #1;
    check("t1_rd_gnt", r0_gnt, 1);
    check("t1_rd_mem_wr", mem_wr, 0);
    check("t1_addr_r", mem_addr_r, 3);
    check("t1_no_rvalid_wr", r0_rvalid, 0);
    @(negedge clk); idle(); #1;
    check("t1_rvalid", r0_rvalid, 1);
    check("t1_rdata", r0_rdata, 32'hA5);
    check("t1_r1_rvalid", r1_rvalid, 0);
    check("t1_addr_w_hold", mem_addr_w, 3);
    check("t1_idle_mem_wr", mem_wr, 0);
    @(negedge clk); #1;
    check("t1_rvalid_drop", r0_rvalid, 0);

    // signed -1 written by r0, read by r1
    @(negedge clk); drive0(1, OP_WR, 0, 3'd0, 32'hFFFF_FFFF); #1;
    check("t5_wr_gnt", r0_gnt, 1);
    @(negedge clk); drive0(0, 0, 0, '0, '0); drive1(1, OP_RD, 0, 3'd0, '0); #1;
    check("t5_rd_gnt", r1_gnt, 1);
    @(negedge clk); idle(); #1;
    check("t5_r1_rvalid", r1_rvalid, 1);
    check("t5_r1_rdata", r1_rdata, 32'hFFFF_FFFF);
    check("t5_r0_rvalid", r0_rvalid, 0);

    // reset mid-operation: locked read, then a write offered during reset
    @(negedge clk); drive0(1, OP_WR, 0, 3'd5, 32'h0000_1234);
    @(negedge clk); drive0(0, 0, 0, '0, '0); drive1(1, OP_RD, 1, 3'd5, '0); #1;
    check("t6_rd_gnt", r1_gnt, 1);
    @(negedge clk); rst = 1'b1; drive1(1, OP_WR, 1, 3'd5, 32'h0000_DEAD); #1;
    check("t6_locked_state", dbg_state, OWN1);
    check("t6_mem_wr_in_rst", mem_wr, 0);
    @(negedge clk); rst = 1'b0; idle(); #1;
    check("t6_r1_rvalid", r1_rvalid, 0);
    check("t6_state", dbg_state, ARB);
    drive0(1, OP_RD, 0, 3'd5, '0);
    @(negedge clk); idle(); #1;
    check("t6_rvalid", r0_rvalid, 1);
    check("t6_no_write", r0_rdata, 32'h0000_1234);

    // table-driven grant/lock sequence from a fresh reset
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, !RR,  RR};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, !RR,  RR};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive0(vecs[i].q0, vecs[i].w0, vecs[i].l0, 3'd1, 32'h0000_0011);
      drive1(vecs[i].q1, vecs[i].w1, vecs[i].l1, 3'd4, 32'h0000_0044);
      #1;
      check($sformatf("vec%0d_gnt0", i), r0_gnt, vecs[i].e0);
      check($sformatf("vec%0d_gnt1", i), r1_gnt, vecs[i].e1);
    end

    // randomized traffic against a transaction-level model
    do_reset();
    for (int a = 0; a < NADDRE; a++) begin
      @(negedge clk);
      d0 = $urandom;
      drive0(1, OP_WR, 0, AW'(a), d0); #1;
      check("init_gnt", r0_gnt, 1);
      mmem[a] = d0;
    end
    owner = -1; lw = 1'b0; erv0 = 1'b0; erv1 = 1'b0; p0 = 1'b0; p1 = 1'b0;
    {w0, w1, l0, l1, a0, a1, d0, d1} = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      check("rnd_r0_rvalid", r0_rvalid, erv0);
      check("rnd_r1_rvalid", r1_rvalid, erv1);
      if (erv0 || erv1) begin
        exp_d = exp_q.pop_front();
        check("rnd_rdata", erv0 ? r0_rdata : r1_rdata, exp_d);
      end
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1; w0 = 1'($urandom_range(0, 1)); l0 = ($urandom_range(0, 2) == 0);
        a0 = AW'($urandom_range(0, NADDRE - 1)); d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1'b1; w1 = 1'($urandom_range(0, 1)); l1 = ($urandom_range(0, 2) == 0);
        a1 = AW'($urandom_range(0, NADDRE - 1)); d1 = $urandom;
      end
      drive0(p0, w0, l0, a0, d0);
      drive1(p1, w1, l1, a1, d1);
      #1;
      g0 = 1'b0; g1 = 1'b0;
      if (owner == 0)        g0 = p0;
      else if (owner == 1)   g1 = p1;
      else if (p0 && p1) begin
        if (RR && lw == 1'b0) g1 = 1'b1;
        else                  g0 = 1'b1;
      end else begin
        g0 = p0; g1 = p1;
      end
      check("rnd_gnt0", r0_gnt, g0);
      check("rnd_gnt1", r1_gnt, g1);
      check("rnd_mem_wr", mem_wr, (g0 && w0) || (g1 && w1));
      erv0 = g0 && !w0;
      erv1 = g1 && !w1;
      if (g0) begin
        if (w0) mmem[a0] = d0; else exp_q.push_back(mmem[a0]);
      end
      if (g1) begin
        if (w1) mmem[a1] = d1; else exp_q.push_back(mmem[a1]);
      end
      if (owner == 0)      begin if (!p0 || !l0) owner = -1; end
      else if (owner == 1) begin if (!p1 || !l1) owner = -1; end
      else if (g0 && l0)   owner = 0;
      else if (g1 && l1)   owner = 1;
      if (g1)      lw = 1'b1;
      else if (g0) lw = 1'b0;
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
